// File: rtl/contador_if.sv
// Handshake/data bundle between a count-run controller and its client.
interface contador_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             stop;
    logic             hold;
    logic             periodic;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [1:0]       state;
    logic [7:0]       periods;

    modport master (
        output start, stop, hold, periodic, limit,
        input  count, busy, done, state, periods
    );

    modport slave (
        input  start, stop, hold, periodic, limit,
        output count, busy, done, state, periods
    );
endinterface

// File: rtl/contador_ctrl.sv
// Run controller for an up-counter: one-shot or auto-restart runs to a latched
// limit, with pause, abort, a one-cycle done pulse and a saturating period tally.
module contador_ctrl #(
    parameter int WIDTH = 16
) (
    input logic       clk,
    input logic       rst,
    contador_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] lim_reg, lim_next;
    logic             mode_reg, mode_next;
    logic             done_reg, done_next;
    logic [7:0]       periods_reg, periods_next;
    logic             accept;
    logic             terminal;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    // A start with a zero limit would terminate immediately, so it is not accepted.
    assign accept   = bus.start && (bus.limit != '0);
    assign terminal = (state_reg == RUN) && (count_reg == lim_reg);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            lim_reg     <= '0;
            mode_reg    <= 1'b0;
            done_reg    <= 1'b0;
            periods_reg <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            lim_reg     <= lim_next;
            mode_reg    <= mode_next;
            done_reg    <= done_next;
            periods_reg <= periods_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        lim_next     = lim_reg;
        mode_next    = mode_reg;
        done_next    = 1'b0;
        periods_next = periods_reg;

        if (bus.stop) begin
            state_next = IDLE;
            count_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    count_next = '0;
                    if (accept) begin
                        state_next   = RUN;
                        lim_next     = bus.limit;
                        mode_next    = bus.periodic;
                        periods_next = '0;
                    end
                end
                RUN: begin
                    // Terminal count outranks hold in the same cycle.
                    if (terminal) begin
                        done_next    = 1'b1;
                        periods_next = sat_inc(periods_reg);
                        if (mode_reg) begin
                            count_next = '0;
                        end else begin
                            state_next = DONE;
                        end
                    end else if (bus.hold) begin
                        state_next = PAUSE;
                    end else begin
                        count_next = count_reg + WIDTH'(1);
                    end
                end
                PAUSE: begin
                    if (!bus.hold) begin
                        state_next = RUN;
                    end
                end
                DONE: begin
                    count_next = lim_reg;
                    if (accept) begin
                        state_next   = RUN;
                        count_next   = '0;
                        lim_next     = bus.limit;
                        mode_next    = bus.periodic;
                        periods_next = '0;
                    end
                end
            endcase
        end
    end

    assign bus.count   = count_reg;
    assign bus.done    = done_reg;
    assign bus.state   = state_reg;
    assign bus.periods = periods_reg;
    assign bus.busy    = (state_reg == RUN) || (state_reg == PAUSE);
endmodule

// File: tb/tb_contador_ctrl.sv
// Bench for contador_ctrl: directed scenarios against literal expectations,
// then a randomized run against a run/pause/finished reference model.
module tb_contador_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    contador_if #(.WIDTH(W)) bus ();
    contador_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: a run is either active (possibly paused) or finished.
    int m_count, m_lim, m_periods;
    bit m_active, m_paused, m_finished, m_mode, m_done;

    function automatic void model_step();
        m_done = 1'b0;
        if (!rst) begin
            m_active = 0; m_paused = 0; m_finished = 0;
            m_count = 0; m_lim = 0; m_mode = 0; m_periods = 0;
        end else if (bus.stop) begin
            m_active = 0; m_paused = 0; m_finished = 0; m_count = 0;
        end else if (m_active && !m_paused && m_count == m_lim) begin
            m_done = 1'b1;
            if (m_periods < 255) m_periods++;
            if (m_mode) m_count = 0;
            else begin m_active = 0; m_finished = 1; end
        end else if (m_active && !m_paused && bus.hold) begin
            m_paused = 1;
        end else if (m_paused) begin
            if (!bus.hold) m_paused = 0;
        end else if (m_active) begin
            m_count = (m_count + 1) % (1 << W);
        end else if (bus.start && bus.limit != 0) begin
            m_active = 1; m_finished = 0; m_count = 0;
            m_lim = int'(bus.limit); m_mode = bus.periodic; m_periods = 0;
        end else if (!m_finished) begin
            m_count = 0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (bus.state !== 2'd0 || bus.count !== '0 || bus.done !== 1'b0 ||
            bus.periods !== 8'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: state=%0d count=%0d done=%0d periods=%0d busy=%0d, expected all 0",
                     bus.state, bus.count, bus.done, bus.periods, bus.busy);
        end
        rst = 1'b1;
    endtask

    task automatic test_oneshot();
        bus.limit = 5; bus.periodic = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            if (i > 0) tick();
            n_tests++;
            if (bus.count !== W'(i) || bus.state !== 2'd1 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL oneshot_run[%0d]: count=%0d state=%0d done=%0d busy=%0d, expected count=%0d state=1 done=0 busy=1",
                         i, bus.count, bus.state, bus.done, bus.busy, i);
            end
        end
        tick();
        n_tests++;
        if (bus.state !== 2'd3 || bus.done !== 1'b1 || bus.count !== W'(5) || bus.periods !== 8'd1) begin
            n_fail++;
            $display("FAIL oneshot_term: state=%0d done=%0d count=%0d periods=%0d, expected 3 1 5 1",
                     bus.state, bus.done, bus.count, bus.periods);
        end
        tick();
        n_tests++;
        if (bus.state !== 2'd3 || bus.done !== 1'b0 || bus.count !== W'(5) || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_after: state=%0d done=%0d count=%0d busy=%0d, expected 3 0 5 0",
                     bus.state, bus.done, bus.count, bus.busy);
        end
    endtask

    task automatic test_periodic();
        bus.limit = 3; bus.periodic = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) tick();
            n_tests++;
            if (bus.count !== W'(k % 4) || bus.done !== ((k > 0) && (k % 4 == 0)) ||
                bus.periods !== 8'(k / 4) || bus.state !== 2'd1) begin
                n_fail++;
                $display("FAIL periodic[%0d]: count=%0d done=%0d periods=%0d state=%0d, expected count=%0d done=%0d periods=%0d state=1",
                         k, bus.count, bus.done, bus.periods, bus.state, k % 4, (k > 0) && (k % 4 == 0), k / 4);
            end
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        n_tests++;
        if (bus.state !== 2'd0 || bus.count !== '0 || bus.done !== 1'b0 || bus.periods !== 8'd3) begin
            n_fail++;
            $display("FAIL periodic_stop: state=%0d count=%0d done=%0d periods=%0d, expected 0 0 0 3",
                     bus.state, bus.count, bus.done, bus.periods);
        end
    endtask

    task automatic test_hold();
        int t;
        bus.limit = 10; bus.periodic = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        t = 4;
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); t++;
            n_tests++;
            if (bus.state !== 2'd2 || bus.count !== W'(4) || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_pause[%0d]: state=%0d count=%0d busy=%0d, expected 2 4 1",
                         i, bus.state, bus.count, bus.busy);
            end
        end
        bus.hold = 1'b0;
        tick(); t++;
        n_tests++;
        if (bus.state !== 2'd1 || bus.count !== W'(4)) begin
            n_fail++;
            $display("FAIL hold_release: state=%0d count=%0d, expected 1 4", bus.state, bus.count);
        end
        tick(); t++;
        n_tests++;
        if (bus.count !== W'(5)) begin
            n_fail++;
            $display("FAIL hold_resume: count=%0d, expected 5", bus.count);
        end
        while (bus.done !== 1'b1 && t < 40) begin
            tick(); t++;
        end
        // Unheld, done would appear 11 edges after the start edge.
        n_tests++;
        if (t !== 15 || bus.count !== W'(10) || bus.state !== 2'd3) begin
            n_fail++;
            $display("FAIL hold_done_delay: edge=%0d count=%0d state=%0d, expected 15 10 3", t, bus.count, bus.state);
        end
    endtask

    task automatic test_stop();
        bus.limit = 20; bus.periodic = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        n_tests++;
        if (bus.state !== 2'd0 || bus.count !== '0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop: state=%0d count=%0d done=%0d busy=%0d, expected 0 0 0 0",
                     bus.state, bus.count, bus.done, bus.busy);
        end
        bus.limit = 0; bus.start = 1'b1;
        repeat (2) tick();
        n_tests++;
        if (bus.state !== 2'd0 || bus.count !== '0) begin
            n_fail++;
            $display("FAIL start_zero_idle: state=%0d count=%0d, expected 0 0", bus.state, bus.count);
        end
        bus.limit = 1;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        bus.limit = 0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_tests++;
        if (bus.state !== 2'd3 || bus.count !== W'(1) || bus.periods !== 8'd1) begin
            n_fail++;
            $display("FAIL start_zero_done: state=%0d count=%0d periods=%0d, expected 3 1 1",
                     bus.state, bus.count, bus.periods);
        end
    endtask

    task automatic test_reset_midrun();
        bus.limit = 20; bus.periodic = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_tests++;
        if (bus.state !== 2'd0 || bus.count !== '0 || bus.done !== 1'b0 ||
            bus.periods !== 8'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midrun: state=%0d count=%0d done=%0d periods=%0d busy=%0d, expected all 0",
                     bus.state, bus.count, bus.done, bus.periods, bus.busy);
        end
        tick();
        n_tests++;
        if (bus.state !== 2'd0 || bus.count !== '0) begin
            n_fail++;
            $display("FAIL reset_no_resume: state=%0d count=%0d, expected 0 0", bus.state, bus.count);
        end
    endtask

    task automatic test_saturate();
        bus.limit = 1; bus.periodic = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (600) tick();
        n_tests++;
        if (bus.periods !== 8'd255 || bus.state !== 2'd1) begin
            n_fail++;
            $display("FAIL periods_saturate: periods=%0d state=%0d, expected 255 1", bus.periods, bus.state);
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic test_all_ones();
        bus.limit = W'((1 << W) - 1); bus.periodic = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat ((1 << W) - 1) tick();
        n_tests++;
        if (bus.count !== W'((1 << W) - 1) || bus.state !== 2'd1 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL all_ones_reach: count=%0d state=%0d done=%0d, expected %0d 1 0",
                     bus.count, bus.state, bus.done, (1 << W) - 1);
        end
        tick();
        n_tests++;
        if (bus.count !== W'((1 << W) - 1) || bus.state !== 2'd3 || bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL all_ones_term: count=%0d state=%0d done=%0d, expected %0d 3 1",
                     bus.count, bus.state, bus.done, (1 << W) - 1);
        end
    endtask

    task automatic test_random();
        int exp_state;
        for (int i = 0; i < 2000; i++) begin
            rst          = ($urandom_range(0, 299) != 0);
            bus.start    = ($urandom_range(0, 3) == 0);
            bus.stop     = ($urandom_range(0, 39) == 0);
            bus.hold     = ($urandom_range(0, 5) == 0);
            bus.periodic = $urandom_range(0, 1);
            bus.limit    = W'($urandom_range(0, 12));
            tick();
            exp_state = m_finished ? 3 : (m_paused ? 2 : (m_active ? 1 : 0));
            n_tests++;
            if (bus.state !== 2'(exp_state) || bus.count !== W'(m_count) || bus.done !== m_done ||
                bus.periods !== 8'(m_periods) || bus.busy !== (m_active || m_paused)) begin
                n_fail++;
                $display("FAIL random[%0d]: state=%0d count=%0d done=%0d periods=%0d busy=%0d, expected %0d %0d %0d %0d %0d",
                         i, bus.state, bus.count, bus.done, bus.periods, bus.busy,
                         exp_state, m_count, m_done, m_periods, m_active || m_paused);
            end
        end
        rst = 1'b1; bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0;
        bus.periodic = 1'b0; bus.limit = '0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_hold();
        test_stop();
        test_reset_midrun();
        test_saturate();
        test_all_ones();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
